morse_element_sequencer: RTL and testbench

//  Times a debounced Morse key, classifies each mark as dot or dash, and groups

---
 rtl/morse_element_sequencer.sv | 155 +++++++++++++++
 tb/tb_morse_element_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_element_sequencer.sv
// Morse element sequencer: times key marks and spaces, classifies dot/dash,
// assembles characters and hands them off over a valid/ack handshake.
module morse_element_sequencer #(
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned DOT_MAX  = 200,
  parameter int unsigned CHAR_GAP = 300,
  parameter int unsigned WORD_GAP = 700,
  parameter int unsigned MAX_LEN  = 6,
  parameter int unsigned CNT_W    = 12
) (
  input  logic               C,
  input  logic               nR,
  input  logic               M,
  input  logic               Ack,
  output logic [MAX_LEN-1:0] Code,
  output logic [2:0]         Len,
  output logic               Ovf,
  output logic               CharV,
  output logic               Lost,
  output logic               WordV,
  output logic [1:0]         StatusY
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] DOT_LIM   = CNT_W'(DOT_MAX);
  localparam logic [CNT_W-1:0] CHAR_LAST = CNT_W'(CHAR_GAP - 1);
  localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(WORD_GAP - 1);
  localparam logic [2:0]       LEN_MAX   = 3'(MAX_LEN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_MARK  = 2'b01,
    S_SPACE = 2'b10,
    S_GAP   = 2'b11
  } state_t;

  state_t             r_state;
  logic [PRE_W-1:0]   r_pre;
  logic [CNT_W-1:0]   r_dur;
  logic [MAX_LEN-1:0] r_acc_code;
  logic [2:0]         r_acc_len;
  logic               r_acc_ovf;

  logic               w_tick;
  logic [CNT_W-1:0]   w_dur_inc;
  logic               w_is_dash;
  logic               w_char_end;
  logic               w_word_end;
  logic [MAX_LEN-1:0] w_bit_mask;

  assign w_tick     = (r_pre == PRE_LAST);
  assign w_dur_inc  = (r_dur == {CNT_W{1'b1}}) ? r_dur : r_dur + CNT_W'(1);
  assign w_is_dash  = (r_dur >= DOT_LIM);
  assign w_char_end = w_tick && (r_dur == CHAR_LAST);
  assign w_word_end = w_tick && (r_dur == WORD_LAST);
  assign w_bit_mask = MAX_LEN'(1) << r_acc_len;
  assign StatusY    = r_state;

  // Timing, accumulation, state sequencing and handshake in one registered process
  always_ff @(posedge C or negedge nR) begin
    if (!nR) begin
      r_state    <= S_IDLE;
      r_pre      <= '0;
      r_dur      <= '0;
      r_acc_code <= '0;
      r_acc_len  <= '0;
      r_acc_ovf  <= 1'b0;
      Code       <= '0;
      Len        <= '0;
      Ovf        <= 1'b0;
      CharV      <= 1'b0;
      Lost       <= 1'b0;
      WordV      <= 1'b0;
    end else begin
      WordV <= 1'b0;
      r_pre <= w_tick ? '0 : r_pre + PRE_W'(1);
      if (w_tick) begin
        r_dur <= w_dur_inc;
      end
      if (CharV && Ack) begin
        CharV <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (M) begin
            r_state    <= S_MARK;
            r_pre      <= '0;
            r_dur      <= '0;
            r_acc_code <= '0;
            r_acc_len  <= '0;
            r_acc_ovf  <= 1'b0;
          end
        end

        S_MARK: begin
          if (!M) begin
            // Key released: classify the mark and append it if there is room
            if (r_acc_len < LEN_MAX) begin
              r_acc_code <= w_is_dash ? (r_acc_code | w_bit_mask) : r_acc_code;
              r_acc_len  <= r_acc_len + 3'd1;
            end else begin
              r_acc_ovf  <= 1'b1;
            end
            r_state <= S_SPACE;
            r_pre   <= '0;
            r_dur   <= '0;
          end
        end

        S_SPACE: begin
          if (w_char_end) begin
            // Character complete: present it and start a fresh accumulator
            Code       <= r_acc_code;
            Len        <= r_acc_len;
            Ovf        <= r_acc_ovf;
            CharV      <= 1'b1;
            if (CharV && !Ack) begin
              Lost <= 1'b1;
            end
            r_acc_code <= '0;
            r_acc_len  <= '0;
            r_acc_ovf  <= 1'b0;
            r_state    <= M ? S_MARK : S_GAP;
            r_pre      <= '0;
            r_dur      <= '0;
          end else if (M) begin
            r_state <= S_MARK;
            r_pre   <= '0;
            r_dur   <= '0;
          end
        end

        S_GAP: begin
          if (M) begin
            r_state <= S_MARK;
            r_pre   <= '0;
            r_dur   <= '0;
          end else if (w_word_end) begin
            WordV   <= 1'b1;
            r_state <= S_IDLE;
            r_pre   <= '0;
            r_dur   <= '0;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_morse_element_sequencer.sv
// Bench for morse_element_sequencer: directed key timing, scoreboarded characters.
module tb_morse_element_sequencer;

  localparam int unsigned ML = 6;

  logic          C;
  logic          nR;
  logic          M;
  logic          Ack;
  logic [ML-1:0] Code;
  logic [2:0]    Len;
  logic          Ovf;
  logic          CharV;
  logic          Lost;
  logic          WordV;
  logic [1:0]    StatusY;

  int checks;
  int errors;
  int word_seen;
  logic [9:0] exp_q[$];

  morse_element_sequencer #(
    .TICK_DIV(2), .DOT_MAX(4), .CHAR_GAP(6), .WORD_GAP(14), .MAX_LEN(ML), .CNT_W(12)
  ) dut (
    .C(C), .nR(nR), .M(M), .Ack(Ack),
    .Code(Code), .Len(Len), .Ovf(Ovf), .CharV(CharV),
    .Lost(Lost), .WordV(WordV), .StatusY(StatusY)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge C);
    #1;
  endtask

  // Key down for k ticks (one cycle for the transition plus 2 cycles per tick)
  task automatic mark(input int k);
    M = 1'b1;
    repeat (2 * k + 1) step();
  endtask

  task automatic space(input int k);
    M = 1'b0;
    repeat (2 * k + 1) step();
  endtask

  task automatic expect_char(input logic [ML-1:0] code, input logic [2:0] len, input logic ovf);
    exp_q.push_back({code, len, ovf});
  endtask

  task automatic ack_pulse();
    Ack = 1'b1;
    step();
    Ack = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_status"}, 32'(StatusY), 0);
    chk({tag, "_charv"},  32'(CharV), 0);
    chk({tag, "_lost"},   32'(Lost), 0);
    chk({tag, "_wordv"},  32'(WordV), 0);
    chk({tag, "_code"},   32'(Code), 0);
    chk({tag, "_len"},    32'(Len), 0);
    chk({tag, "_ovf"},    32'(Ovf), 0);
  endtask

  // Monitor: a character is presented when CharV rises or its payload changes
  initial begin
    logic       prev_v;
    logic [9:0] prev_d;
    logic [9:0] got;
    logic [9:0] e;
    prev_v = 1'b0;
    prev_d = '0;
    forever begin
      @(negedge C);
      got = {Code, Len, Ovf};
      if (nR === 1'b1) begin
        if (WordV === 1'b1) word_seen++;
        if (CharV === 1'b1 && (!prev_v || got != prev_d)) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL char_unexpected: got code=%b len=%0d ovf=%0d, none expected",
                     Code, Len, Ovf);
          end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
              errors++;
              $display("FAIL char_data: got code=%b len=%0d ovf=%0d expected code=%b len=%0d ovf=%0d",
                       Code, Len, Ovf, e[9:4], e[3:1], e[0]);
            end
          end
        end
      end
      prev_v = CharV;
      prev_d = got;
    end
  end

  initial begin
    int wcnt;
    int wpos;
    logic [1:0] wstat;
    checks = 0;
    errors = 0;
    word_seen = 0;
    nR = 1'b0;
    M = 1'b0;
    Ack = 1'b0;
    repeat (2) step();
    nR = 1'b1;
    chk_all_zero("rst_init");

    // 1. Reset behaviour
    M = 1'b1;
    repeat (10) step();
    chk("mark_status", 32'(StatusY), 1);
    #2 nR = 1'b0;
    #1 chk_all_zero("rst_async");
    nR = 1'b1;
    repeat (3) step();
    chk("post_rst_status", 32'(StatusY), 1);
    expect_char(6'b000000, 3'd1, 1'b0);
    space(6);
    ack_pulse();

    // 2. "A" with emit latency and acknowledge
    expect_char(6'b000010, 3'd2, 1'b0);
    mark(2);
    space(2);
    mark(6);
    M = 1'b0;
    repeat (12) step();
    chk("a_pre_emit", 32'(CharV), 0);
    step();
    chk("a_charv", 32'(CharV), 1);
    chk("a_status_gap", 32'(StatusY), 3);
    ack_pulse();
    chk("a_ack_clear", 32'(CharV), 0);

    // 3. Dot/dash threshold
    expect_char(6'b000000, 3'd1, 1'b0);
    mark(3);
    space(6);
    ack_pulse();
    expect_char(6'b000001, 3'd1, 1'b0);
    mark(4);
    space(6);
    ack_pulse();

    // 4. Overflow: seven dots
    expect_char(6'b000000, 3'd6, 1'b1);
    for (int i = 0; i < 6; i++) begin
      mark(1);
      space(2);
    end
    mark(1);
    space(6);
    ack_pulse();

    // 5a. Word gap after "E"
    expect_char(6'b000000, 3'd1, 1'b0);
    mark(1);
    space(6);
    ack_pulse();
    wcnt = 0;
    wpos = 0;
    wstat = 2'b11;
    for (int i = 2; i <= 32; i++) begin
      step();
      if (WordV === 1'b1) begin
        wcnt++;
        wpos = i;
        wstat = StatusY;
      end
    end
    chk("word_pulse_count", 32'(wcnt), 1);
    chk("word_pulse_pos", 32'(wpos), 28);
    chk("word_status_idle", 32'(wstat), 0);

    // 5b. Key pressed at 10 gap ticks: no word
    expect_char(6'b000000, 3'd1, 1'b0);
    mark(1);
    space(6);
    ack_pulse();
    repeat (19) step();
    M = 1'b1;
    step();
    chk("gap_press_status", 32'(StatusY), 1);
    wcnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (WordV === 1'b1) wcnt++;
    end
    chk("gap_press_no_word", 32'(wcnt), 0);

    // 6a. Two characters without Ack
    expect_char(6'b000001, 3'd1, 1'b0);
    space(6);
    chk("first_lost", 32'(Lost), 0);
    expect_char(6'b000000, 3'd2, 1'b0);
    mark(1);
    space(2);
    mark(1);
    space(6);
    chk("over_charv", 32'(CharV), 1);
    chk("over_lost", 32'(Lost), 1);

    // Reset mid-character discards the partial character
    mark(2);
    #2 nR = 1'b0;
    #1 chk_all_zero("rst_mid");
    M = 1'b0;
    nR = 1'b1;
    repeat (20) step();
    chk("rst_mid_no_char", 32'(CharV), 0);
    chk("rst_mid_idle", 32'(StatusY), 0);

    // 6b. Emit coincident with Ack
    expect_char(6'b000001, 3'd1, 1'b0);
    mark(4);
    space(6);
    expect_char(6'b000001, 3'd2, 1'b0);
    mark(4);
    space(2);
    mark(1);
    M = 1'b0;
    repeat (12) step();
    Ack = 1'b1;
    step();
    Ack = 1'b0;
    chk("ack_emit_charv", 32'(CharV), 1);
    chk("ack_emit_lost", 32'(Lost), 0);
    ack_pulse();
    chk("final_ack_clear", 32'(CharV), 0);

    repeat (3) step();
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    chk("word_total", 32'(word_seen), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
